// File: rtl/uart_txrx.sv
// rtl/uart_txrx.sv - UART transmitter/receiver with shared baud tick and RX FIFO
module uart_txrx #(
    parameter int DIV_W    = 16,
    parameter int OVS      = 16,
    parameter int RX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_stop2,
    input  logic             cfg_par_en,
    input  logic             cfg_par_even,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             txd,
    input  logic             rxd,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_par_err,
    output logic             rx_frm_err,
    output logic             rx_overrun
);

    localparam int CW = $clog2(OVS);
    localparam int AW = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] OVS_M1  = CW'(OVS - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVS / 2 - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(RX_DEPTH);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // ---------------------------------------------------------------- tick
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;
    logic             r_out_en;

    // >= rather than == so a shrinking cfg_div cannot strand the counter
    assign w_tick = (r_div_cnt >= cfg_div);

    // Free-running divisor counter, wraps after cfg_div
    always_ff @(posedge clk) begin
        if (!rst_n)       r_div_cnt <= '0;
        else if (w_tick)  r_div_cnt <= '0;
        else              r_div_cnt <= r_div_cnt + 1'b1;
    end

    // Holds tx_ready low while in reset and releases it one clk after
    always_ff @(posedge clk) begin
        if (!rst_n) r_out_en <= 1'b0;
        else        r_out_en <= 1'b1;
    end

    // ---------------------------------------------------------------- TX
    tx_state_t        r_tx_state, w_tx_next;
    logic [CW-1:0]    r_tx_tcnt;
    logic [2:0]       r_tx_bit;
    logic [2:0]       r_tx_last;
    logic [7:0]       r_tx_data;
    logic             r_tx_par;
    logic             r_tx_par_en;
    logic             r_tx_stop2;
    logic             w_tx_accept;
    logic             w_tx_bit_end;
    logic             w_txd;
    logic [7:0]       w_tx_mask;
    logic             w_tx_par;

    assign tx_ready     = r_out_en && (r_tx_state == TX_IDLE);
    assign w_tx_accept  = tx_valid && tx_ready;
    assign w_tx_bit_end = w_tick && (r_tx_tcnt == OVS_M1);
    assign w_tx_mask    = 8'hFF >> (2'd3 - cfg_data_bits);
    assign w_tx_par     = (^(tx_data & w_tx_mask)) ^ ~cfg_par_even;
    assign txd          = w_txd;

    // TX next-state and serial line value
    always_comb begin
        w_tx_next = r_tx_state;
        w_txd     = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_tx_accept) w_tx_next = TX_START;
            end
            TX_START: begin
                w_txd = 1'b0;
                if (w_tx_bit_end) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                w_txd = r_tx_data[r_tx_bit];
                if (w_tx_bit_end && (r_tx_bit == r_tx_last))
                    w_tx_next = r_tx_par_en ? TX_PARITY : TX_STOP1;
            end
            TX_PARITY: begin
                w_txd = r_tx_par;
                if (w_tx_bit_end) w_tx_next = TX_STOP1;
            end
            TX_STOP1: begin
                if (w_tx_bit_end) w_tx_next = r_tx_stop2 ? TX_STOP2 : TX_IDLE;
            end
            TX_STOP2: begin
                if (w_tx_bit_end) w_tx_next = TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    // TX state register plus per-frame latched data/config and bit timers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_state  <= TX_IDLE;
            r_tx_tcnt   <= '0;
            r_tx_bit    <= '0;
            r_tx_last   <= '0;
            r_tx_data   <= '0;
            r_tx_par    <= 1'b0;
            r_tx_par_en <= 1'b0;
            r_tx_stop2  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_accept) begin
                r_tx_data   <= tx_data;
                r_tx_last   <= 3'(cfg_data_bits) + 3'd4;
                r_tx_par    <= w_tx_par;
                r_tx_par_en <= cfg_par_en;
                r_tx_stop2  <= cfg_stop2;
                r_tx_tcnt   <= '0;
                r_tx_bit    <= '0;
            end else if ((r_tx_state != TX_IDLE) && w_tick) begin
                r_tx_tcnt <= w_tx_bit_end ? '0 : r_tx_tcnt + 1'b1;
                if ((r_tx_state == TX_DATA) && w_tx_bit_end)
                    r_tx_bit <= r_tx_bit + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- RX
    rx_state_t        r_rx_state, w_rx_next;
    logic             r_rx_sync1, r_rx_sync2;
    logic             r_rx_prev;
    logic [CW-1:0]    r_rx_tcnt;
    logic [2:0]       r_rx_bit;
    logic [2:0]       r_rx_last;
    logic [7:0]       r_rx_data;
    logic             r_rx_par_en;
    logic             r_rx_par_even;
    logic             r_rx_stop2;
    logic             r_rx_stop_idx;
    logic             r_rx_par_err;
    logic             r_rx_frm_err;
    logic             w_rxd;
    logic             w_rx_start_det;
    logic             w_rx_half;
    logic             w_rx_full;
    logic             w_rx_push;
    logic [9:0]       w_rx_entry;

    assign w_rxd          = r_rx_sync2;
    assign w_rx_start_det = w_tick && r_rx_prev && !w_rxd;
    assign w_rx_half      = w_tick && (r_rx_tcnt == HALF_M1);
    assign w_rx_full      = w_tick && (r_rx_tcnt == OVS_M1);
    // Frame error includes the stop sample taken in the push cycle itself
    assign w_rx_entry     = {r_rx_data, r_rx_par_err, r_rx_frm_err | ~w_rxd};

    // Two-flop synchroniser for the asynchronous serial input, idles high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
        end else begin
            r_rx_sync1 <= rxd;
            r_rx_sync2 <= r_rx_sync1;
        end
    end

    // RX next-state; push strobe on the final stop sample
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_push = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_rx_start_det) w_rx_next = RX_START;
            end
            RX_START: begin
                if (w_rx_half) w_rx_next = w_rxd ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_rx_full && (r_rx_bit == r_rx_last))
                    w_rx_next = r_rx_par_en ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (w_rx_full) w_rx_next = RX_STOP;
            end
            RX_STOP: begin
                if (w_rx_full && !(r_rx_stop2 && !r_rx_stop_idx)) begin
                    w_rx_push = 1'b1;
                    w_rx_next = RX_IDLE;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // RX state register, tick-rate edge history, sampling timers and shift data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_state    <= RX_IDLE;
            r_rx_prev     <= 1'b1;
            r_rx_tcnt     <= '0;
            r_rx_bit      <= '0;
            r_rx_last     <= '0;
            r_rx_data     <= '0;
            r_rx_par_en   <= 1'b0;
            r_rx_par_even <= 1'b0;
            r_rx_stop2    <= 1'b0;
            r_rx_stop_idx <= 1'b0;
            r_rx_par_err  <= 1'b0;
            r_rx_frm_err  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            if (w_tick) r_rx_prev <= w_rxd;
            if (r_rx_state == RX_IDLE) begin
                if (w_rx_start_det) begin
                    r_rx_last     <= 3'(cfg_data_bits) + 3'd4;
                    r_rx_par_en   <= cfg_par_en;
                    r_rx_par_even <= cfg_par_even;
                    r_rx_stop2    <= cfg_stop2;
                    r_rx_tcnt     <= '0;
                    r_rx_bit      <= '0;
                    r_rx_data     <= '0;
                    r_rx_stop_idx <= 1'b0;
                    r_rx_par_err  <= 1'b0;
                    r_rx_frm_err  <= 1'b0;
                end
            end else if (w_tick) begin
                if (((r_rx_state == RX_START) && w_rx_half) || w_rx_full)
                    r_rx_tcnt <= '0;
                else
                    r_rx_tcnt <= r_rx_tcnt + 1'b1;
                if ((r_rx_state == RX_DATA) && w_rx_full) begin
                    r_rx_data[r_rx_bit] <= w_rxd;
                    r_rx_bit            <= r_rx_bit + 1'b1;
                end
                if ((r_rx_state == RX_PARITY) && w_rx_full)
                    r_rx_par_err <= w_rxd ^ (^r_rx_data) ^ ~r_rx_par_even;
                if ((r_rx_state == RX_STOP) && w_rx_full) begin
                    r_rx_frm_err  <= r_rx_frm_err | ~w_rxd;
                    r_rx_stop_idx <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- FIFO
    logic [9:0]  r_fifo_mem [RX_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;
    logic          w_full;
    logic          w_pop;
    logic          w_push_ok;
    logic [9:0]    w_head;

    assign w_full     = (r_count == DEPTH_C);
    assign rx_valid   = (r_count != '0);
    assign w_pop      = rx_valid && rx_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign w_push_ok  = w_rx_push && (!w_full || w_pop);
    assign w_head     = r_fifo_mem[r_rd_ptr];
    assign rx_data    = rx_valid ? w_head[9:2] : 8'h00;
    assign rx_par_err = rx_valid && w_head[1];
    assign rx_frm_err = rx_valid && w_head[0];
    assign rx_overrun = r_overrun;

    // Storage array needs no reset; rx_valid masks stale entries
    always_ff @(posedge clk) begin
        if (w_push_ok) r_fifo_mem[r_wr_ptr] <= w_rx_entry;
    end

    // FIFO pointers, occupancy and overrun pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_rx_push && !w_push_ok;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txrx.sv
// tb/tb_uart_txrx.sv - randomized self-checking bench for uart_txrx
module tb_uart_txrx;

    localparam int OVS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cfg_data_bits = 2'd3;
    logic        cfg_stop2 = 1'b0;
    logic        cfg_par_en = 1'b0;
    logic        cfg_par_even = 1'b0;
    logic [15:0] cfg_div = 16'd0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        txd;
    logic        rxd;
    logic        rxd_drv = 1'b1;
    logic        loop = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_par_err;
    logic        rx_frm_err;
    logic        rx_overrun;

    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;

    assign rxd = loop ? txd : rxd_drv;

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_overrun === 1'b1) ovr_cnt++;

    uart_txrx #(.DIV_W(16), .OVS(OVS), .RX_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_data_bits(cfg_data_bits), .cfg_stop2(cfg_stop2),
        .cfg_par_en(cfg_par_en), .cfg_par_even(cfg_par_even), .cfg_div(cfg_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd),
        .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_par_err(rx_par_err), .rx_frm_err(rx_frm_err), .rx_overrun(rx_overrun)
    );

    // Reference frame: start, data LSB first, optional parity, stop bit(s)
    task automatic build_frame(input logic [7:0] d, input logic [1:0] db,
                               input logic pe, input logic pev, input logic s2,
                               input logic flip, input logic st1, input logic st2,
                               output logic [11:0] f, output int n);
        int nb;
        int ones;
        nb = int'(db) + 5;
        ones = 0;
        f = '1;
        n = 0;
        f[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin
            f[n] = d[i];
            if (d[i]) ones++;
            n++;
        end
        if (pe) begin
            f[n] = (pev ? (ones % 2 == 1) : (ones % 2 == 0)) ^ flip;
            n++;
        end
        f[n] = st1; n++;
        if (s2) begin f[n] = st2; n++; end
    endtask

    function automatic logic [7:0] data_mask(input logic [1:0] db);
        return 8'((1 << (int'(db) + 5)) - 1);
    endfunction

    task automatic set_cfg(input int div, input logic [1:0] db, input logic pe,
                           input logic pev, input logic s2);
        cfg_div = 16'(div); cfg_data_bits = db; cfg_par_en = pe;
        cfg_par_even = pev; cfg_stop2 = s2;
    endtask

    // Sends one byte and checks txd at every bit centre; returns clk count to tx_ready
    task automatic send_check(input string name, input logic [7:0] d, input int div,
                              input logic [1:0] db, input logic pe, input logic pev,
                              input logic s2, input logic scramble, output int ready_k);
        logic [11:0] f;
        int n;
        int k;
        int limit;
        set_cfg(div, db, pe, pev, s2);
        build_frame(d, db, pe, pev, s2, 1'b0, 1'b1, 1'b1, f, n);
        k = 0;
        while (tx_ready !== 1'b1 && k < 4000) begin @(negedge clk); k++; end
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_wait: tx_ready=%b required 1", name, tx_ready);
        end
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'($urandom);
        if (scramble) begin
            cfg_data_bits = 2'($urandom); cfg_par_en = 1'($urandom);
            cfg_par_even = 1'($urandom); cfg_stop2 = 1'($urandom);
        end
        tests++;
        if (tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s busy: tx_ready=%b required 0", name, tx_ready);
        end
        k = 0;
        for (int i = 0; i < n; i++) begin
            while (k < (i * OVS + OVS / 2) * (div + 1)) begin @(negedge clk); k++; end
            tests++;
            if (txd !== f[i]) begin
                fails++;
                $display("FAIL %s txd_bit%0d: got %b required %b", name, i, txd, f[i]);
            end
        end
        limit = k + 2 * OVS * (div + 1);
        while (tx_ready !== 1'b1 && k < limit) begin @(negedge clk); k++; end
        ready_k = k;
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_return: tx_ready=%b required 1", name, tx_ready);
        end
    endtask

    task automatic drive_rx_frame(input logic [11:0] f, input int n, input int div);
        for (int i = 0; i < n; i++) begin
            rxd_drv = f[i];
            repeat (OVS * (div + 1)) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (OVS * (div + 1)) @(negedge clk);
    endtask

    // Waits for a head entry, compares it, then pops it
    task automatic check_head(input string name, input logic [7:0] ed,
                              input logic epe, input logic efe);
        int k;
        k = 0;
        while (rx_valid !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        tests++;
        if (rx_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s rx_valid: got %b required 1", name, rx_valid);
        end
        tests++;
        if (rx_data !== ed || rx_par_err !== epe || rx_frm_err !== efe) begin
            fails++;
            $display("FAIL %s head: got data=%h par=%b frm=%b required data=%h par=%b frm=%b",
                     name, rx_data, rx_par_err, rx_frm_err, ed, epe, efe);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (txd !== 1'b1 || tx_ready !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00 ||
            rx_par_err !== 1'b0 || rx_frm_err !== 1'b0 || rx_overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: txd=%b rdy=%b rv=%b rd=%h pe=%b fe=%b ov=%b required 1 0 0 00 0 0 0",
                     txd, tx_ready, rx_valid, rx_data, rx_par_err, rx_frm_err, rx_overrun);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b required 1", tx_ready);
        end
    endtask

    task automatic test_tx_a5;
        int rk;
        send_check("tx_a5", 8'hA5, 0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, rk);
        tests++;
        if (rk != 160) begin
            fails++;
            $display("FAIL tx_a5_ready_latency: got %0d clk required 160", rk);
        end
    endtask

    task automatic test_tx_random;
        int rk;
        for (int it = 0; it < 6; it++)
            send_check("tx_rand", 8'($urandom), int'($urandom_range(0, 2)), 2'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom), 1'b1, rk);
        set_cfg(0, 2'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_loopback;
        int rk;
        logic [7:0] d;
        logic [1:0] db;
        loop = 1'b1;
        send_check("loop_7e2", 8'h35, 0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, rk);
        check_head("loop_7e2", 8'h35, 1'b0, 1'b0);
        for (int it = 0; it < 4; it++) begin
            d = 8'($urandom);
            db = 2'($urandom);
            send_check("loop_rand", d, int'($urandom_range(0, 2)), db,
                       1'($urandom), 1'($urandom), 1'($urandom), 1'b0, rk);
            check_head("loop_rand", d & data_mask(db), 1'b0, 1'b0);
        end
        loop = 1'b0;
        set_cfg(0, 2'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_rx_errors;
        logic [11:0] f;
        int n;
        set_cfg(0, 2'd3, 1'b1, 1'b0, 1'b0);
        build_frame(8'h55, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, f, n);
        drive_rx_frame(f, n, 0);
        check_head("rx_err_55", 8'h55, 1'b1, 1'b1);
    endtask

    task automatic test_rx_random;
        logic [11:0] f;
        int n, div;
        logic [7:0] d;
        logic [1:0] db;
        logic pe, pev, s2, flip, st1, st2;
        for (int it = 0; it < 8; it++) begin
            d = 8'($urandom); db = 2'($urandom); div = int'($urandom_range(0, 2));
            pe = 1'($urandom); pev = 1'($urandom); s2 = 1'($urandom);
            flip = pe & 1'($urandom);
            st1 = ($urandom % 4) != 0;
            st2 = s2 ? (($urandom % 4) != 0) : 1'b1;
            set_cfg(div, db, pe, pev, s2);
            build_frame(d, db, pe, pev, s2, flip, st1, st2, f, n);
            drive_rx_frame(f, n, div);
            check_head("rx_rand", d & data_mask(db), flip, !st1 || (s2 && !st2));
        end
        set_cfg(0, 2'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun;
        logic [11:0] f;
        int n;
        int base;
        base = ovr_cnt;
        set_cfg(0, 2'd3, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            build_frame(8'(j), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, f, n);
            drive_rx_frame(f, n, 0);
            if (j == 4) begin
                tests++;
                if (ovr_cnt - base != 0) begin
                    fails++;
                    $display("FAIL overrun_early: got %0d pulses required 0", ovr_cnt - base);
                end
            end
        end
        tests++;
        if (ovr_cnt - base != 1) begin
            fails++;
            $display("FAIL overrun_fifth: got %0d pulses required 1", ovr_cnt - base);
        end
        for (int j = 1; j <= 4; j++) check_head("overrun_pop", 8'(j), 1'b0, 1'b0);
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL overrun_empty: rx_valid=%b required 0", rx_valid);
        end
    endtask

    task automatic test_glitch;
        logic [11:0] f;
        int n;
        set_cfg(0, 2'd3, 1'b0, 1'b0, 1'b0);
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (3 * OVS) @(negedge clk);
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL glitch_no_push: rx_valid=%b required 0", rx_valid);
        end
        build_frame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, f, n);
        drive_rx_frame(f, n, 0);
        check_head("glitch_next", 8'h3C, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        logic [11:0] f;
        int n;
        set_cfg(0, 2'd3, 1'b0, 1'b0, 1'b0);
        build_frame(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, f, n);
        drive_rx_frame(f, n, 0);
        tests++;
        if (rx_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pre_rx: rx_valid=%b required 1", rx_valid);
        end
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3 * OVS) @(negedge clk);
        tests++;
        if (tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_busy: tx_ready=%b required 0", tx_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (txd !== 1'b1 || rx_valid !== 1'b0 || tx_ready !== 1'b0 || rx_data !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid_state: txd=%b rv=%b rdy=%b rd=%h required 1 0 0 00",
                     txd, rx_valid, tx_ready, rx_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (tx_ready !== 1'b1 || txd !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_release: tx_ready=%b txd=%b required 1 1", tx_ready, txd);
        end
    endtask

    initial begin
        test_reset;
        test_tx_a5;
        test_tx_random;
        test_loopback;
        test_rx_errors;
        test_rx_random;
        test_overrun;
        test_glitch;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
